// File: rtl/btn_move_ctrl_pkg.sv
// Shared types and constants for the pushbutton movement controller.
// Covers the per-button FSM state encoding and the button bit positions.
package btn_move_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } moveState_e;

    localparam int UP       = 0;
    localparam int DOWN     = 1;
    localparam int LEFT     = 2;
    localparam int RIGHT    = 3;
    localparam int NUM_BTNS = 4;

    // When both buttons of an opposing pair are held, every step in that pair is suppressed.
    function automatic logic [NUM_BTNS-1:0] oppositeMask(input logic [NUM_BTNS-1:0] levels);
        logic [NUM_BTNS-1:0] mask;
        mask = '0;
        if (levels[UP] && levels[DOWN]) begin
            mask[UP]   = 1'b1;
            mask[DOWN] = 1'b1;
        end
        if (levels[LEFT] && levels[RIGHT]) begin
            mask[LEFT]  = 1'b1;
            mask[RIGHT] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/btn_move_ctrl_debounce.sv
// Single-bit pushbutton conditioner: a 2-flop synchronizer followed by a stability counter.
// levelNext is the value level takes at the next edge; the move FSM uses it so that its step lines up with the accepted edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic levelNext
);

    localparam logic [31:0] STABLE_TERM = 32'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  syncQ;
    logic [31:0] stableCnt;
    logic        differs;

    assign differs = (syncQ[1] != level);

    // The synchronized value must differ from level for DEBOUNCE_CYCLES consecutive cycles before level follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ     <= 2'b00;
            stableCnt <= '0;
            level     <= 1'b0;
        end else begin
            syncQ <= {syncQ[0], raw};
            if (!differs) begin
                stableCnt <= '0;
            end else if (stableCnt == STABLE_TERM) begin
                level     <= ~level;
                stableCnt <= '0;
            end else if (stableCnt < STABLE_TERM) begin
                stableCnt <= stableCnt + 32'd1;
            end
        end
    end

    always_comb begin
        levelNext = level;
        if (differs && (stableCnt == STABLE_TERM)) begin
            levelNext = ~level;
        end
    end

endmodule

// File: rtl/btn_move_ctrl.sv
// Debounces four direction buttons and turns each held button into a step strobe with delayed auto-repeat.
// When opposing directions are both held, their steps are cancelled; btnClk2 is the combined move strobe.
module btn_move_ctrl
    import btn_move_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btns_raw,
    output logic [NUM_BTNS-1:0] btns,
    output logic [NUM_BTNS-1:0] step,
    output logic                btnClk2
);

    localparam logic [31:0] DELAY_TERM  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_TERM = 32'(REPEAT_PERIOD - 1);

    logic [NUM_BTNS-1:0] levelNext;
    logic [NUM_BTNS-1:0] stepReq;
    logic [NUM_BTNS-1:0] cancelMask;
    logic [NUM_BTNS-1:0] stepGated;
    moveState_e          state  [NUM_BTNS];
    logic [31:0]         repCnt [NUM_BTNS];

    for (genvar g = 0; g < NUM_BTNS; g++) begin : genDebounce
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uDebounce (
            .clk      (clk),
            .rst      (rst),
            .raw      (btns_raw[g]),
            .level    (btns[g]),
            .levelNext(levelNext[g])
        );
    end

    // Decide which FSMs fire on the coming edge, judged against the level the button is about to take.
    always_comb begin
        stepReq = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            case (state[i])
                IDLE:    stepReq[i] = levelNext[i];
                DELAY:   stepReq[i] = levelNext[i] && (repCnt[i] == DELAY_TERM);
                REPEAT:  stepReq[i] = levelNext[i] && (repCnt[i] == PERIOD_TERM);
                default: stepReq[i] = 1'b0;
            endcase
        end
        cancelMask = oppositeMask(levelNext);
        stepGated  = stepReq & ~cancelMask;
    end

    // Per-button press/delay/repeat FSMs; the cancel only masks the strobes, so the FSMs keep their timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                state[i]  <= IDLE;
                repCnt[i] <= '0;
            end
            step    <= '0;
            btnClk2 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (!levelNext[i]) begin
                    state[i]  <= IDLE;
                    repCnt[i] <= '0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            state[i]  <= DELAY;
                            repCnt[i] <= '0;
                        end
                        DELAY: begin
                            if (repCnt[i] == DELAY_TERM) begin
                                state[i]  <= REPEAT;
                                repCnt[i] <= '0;
                            end else if (repCnt[i] < DELAY_TERM) begin
                                repCnt[i] <= repCnt[i] + 32'd1;
                            end
                        end
                        REPEAT: begin
                            if (repCnt[i] == PERIOD_TERM) begin
                                repCnt[i] <= '0;
                            end else if (repCnt[i] < PERIOD_TERM) begin
                                repCnt[i] <= repCnt[i] + 32'd1;
                            end
                        end
                        default: begin
                            state[i]  <= IDLE;
                            repCnt[i] <= '0;
                        end
                    endcase
                end
            end
            step    <= stepGated;
            btnClk2 <= |stepGated;
        end
    end

endmodule

// File: doc/btn_move_ctrl.md
BTN_MOVE_CTRL -- requirements
Module: btn_move_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 40000000: hold cycles from the first step to the first auto-repeat step.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat steps.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btns_raw, input, 4 bits: asynchronous pushbutton pins; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-007 SHALL have port btns, output, 4 bits: debounced button levels, same bit order, consumed by the player object.
REQ-008 SHALL have port step, output, 4 bits: one-cycle move strobes per direction.
REQ-009 SHALL have port btnClk2, output, 1 bit: OR of step after opposite-cancel; the player's move strobe.

Function
REQ-010 SHALL pass each btns_raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep a per-bit 32-bit stability counter, cleared whenever the synchronized value equals btns[i], else incremented.
REQ-012 SHALL toggle btns[i] and clear the counter on the cycle the counter reaches DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-013 SHALL ignore glitches shorter than DEBOUNCE_CYCLES with no change on btns.
REQ-014 SHALL run one 3-state FSM per bit: IDLE, DELAY, REPEAT.
REQ-015 IDLE: SHALL move to DELAY, load the repeat counter with 0 and assert step[i] for one cycle in the first cycle btns[i] reads 1.
REQ-016 DELAY: SHALL count each held cycle and, when REPEAT_DELAY cycles have elapsed since the IDLE step, assert step[i] once, clear the counter and move to REPEAT.
REQ-017 REPEAT: SHALL assert step[i] once every REPEAT_PERIOD cycles while btns[i]=1.
REQ-018 SHALL return from any state to IDLE in the first cycle btns[i] reads 0, clear the counter and assert no step in that cycle.
REQ-019 step SHALL be registered (zero combinational path from inputs) and SHALL be high for exactly one cycle per event.
REQ-020 Opposite-cancel: SHALL force the step pair [1:0] to 0 in any cycle btns[0]&btns[1]=1, and [3:2] likewise for btns[2]&btns[3]=1; FSMs keep running.
REQ-021 SHALL let non-opposite directions (e.g. up+right) step independently and simultaneously.
REQ-022 SHALL saturate counters at their terminal value and never wrap.
REQ-023 Parameter values below 2 are unsupported; no behaviour is required for them.

Reset
REQ-024 On rst=1, SHALL asynchronously set btns=0, step=0, btnClk2=0, synchronizers=0, all counters=0 and all FSMs=IDLE.
REQ-025 A reset asserted mid-hold SHALL drop all outputs immediately.
REQ-026 After rst release, a held button SHALL need a full new debounce before step.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding (IDLE=0, DELAY=1, REPEAT=2) and the bit-index constants UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-028 SHALL contain one sub-module, btn_debounce (synchronizer + stability counter, one bit, parameter DEBOUNCE_CYCLES), instantiated 4 times.
REQ-029 The FSM, repeat counters and cancel logic SHALL reside in btn_move_ctrl.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-030 Clean press: btns_raw[0] rises and holds -> btns[0]=1 six cycles later (2 sync + 4 stable); step[0] and btnClk2 pulse for one cycle in that same cycle.
REQ-031 Bounce: btns_raw[2] toggles with 3-cycle highs for 30 cycles -> btns[2] stays 0 and step stays 0.
REQ-032 Hold for 25 cycles after acceptance -> steps at relative cycles 0, 10, 13, 16, 19, 22; release -> no further step; FSM returns to IDLE.
REQ-033 Opposite: up and down pressed together -> btns=4'b0011 with step[1:0]=0 and btnClk2=0 throughout; release down -> up steps at the next REPEAT boundary.
REQ-034 Diagonal: up+right pressed in the same cycle -> step=4'b1001 in a single cycle, btnClk2=1.
REQ-035 Async reset during REPEAT -> outputs go to 0 before the next clk edge; with the button still held after release, the first step occurs six cycles later.
